// File: rtl/tb_run_ctrl.sv
// Run controller for core-level simulation and FPGA bring-up: sequences core reset, counts cycles/instructions,
// detects jump-to-self halt or cycle-budget timeout. Define TB_RUN_CTRL_ECALL_EN to treat ecall as an immediate halt.
module tb_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter logic [31:0] HALT_INSN   = 32'h0000006f,
  parameter int unsigned HALT_REPEAT = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_restart,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_insn,
  input  logic             i_insn_vld,
  output logic             o_core_rst_n,
  output logic             o_running,
  output logic             o_done,
  output logic             o_done_pulse,
  output logic             o_halted,
  output logic             o_timeout,
`ifdef TB_RUN_CTRL_ECALL_EN
  output logic             o_ecall,
`endif
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_insn_cnt
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_TGT    = REP_W'(HALT_REPEAT);
  localparam logic [REP_W-1:0]  REP_MAX    = {REP_W{1'b1}};
  localparam logic [CNT_W-1:0]  CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]       ECALL_INSN = 32'h00000073;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  insn_cnt_q, insn_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
`ifdef TB_RUN_CTRL_ECALL_EN
  logic              ecall_q, ecall_d;
  logic              ecall_hit_s;
`endif

  logic [REP_W-1:0]  rep_next_s;
  logic              halt_hit_s;
  logic              halt_any_s;
  logic              timeout_hit_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Halt pattern tracking: only valid cycles touch the repeat count.
  always_comb begin
    rep_next_s = rep_cnt_q;
    halt_hit_s = 1'b0;
`ifdef TB_RUN_CTRL_ECALL_EN
    ecall_hit_s = 1'b0;
`endif
    if (i_insn_vld) begin
      if (i_insn == HALT_INSN) begin
        if (i_pc == last_pc_q) begin
          if (rep_cnt_q != REP_MAX) begin
            rep_next_s = rep_cnt_q + REP_W'(1);
          end else begin
            rep_next_s = rep_cnt_q;
          end
        end else begin
          rep_next_s = REP_W'(1);
        end
      end else begin
        rep_next_s = {REP_W{1'b0}};
      end
      halt_hit_s = (rep_next_s >= REP_TGT);
`ifdef TB_RUN_CTRL_ECALL_EN
      ecall_hit_s = (i_insn == ECALL_INSN);
`endif
    end else begin
      rep_next_s = rep_cnt_q;
    end
`ifdef TB_RUN_CTRL_ECALL_EN
    halt_any_s = halt_hit_s | ecall_hit_s;
`else
    halt_any_s = halt_hit_s;
`endif
    timeout_hit_s = (cycle_cnt_q == CYC_LAST);
  end

  // Next-state and registered-output logic; restart overrides everything.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    insn_cnt_d   = insn_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    last_pc_d    = last_pc_q;
    core_rst_n_d = core_rst_n_q;
    done_pulse_d = 1'b0;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
`ifdef TB_RUN_CTRL_ECALL_EN
    ecall_d      = ecall_q;
`endif
    if (i_restart) begin
      state_d      = ST_HOLD;
      hold_cnt_d   = {HOLD_W{1'b0}};
      cycle_cnt_d  = {CNT_W{1'b0}};
      insn_cnt_d   = {CNT_W{1'b0}};
      rep_cnt_d    = {REP_W{1'b0}};
      last_pc_d    = 32'h00000000;
      core_rst_n_d = 1'b0;
      halted_d     = 1'b0;
      timeout_d    = 1'b0;
`ifdef TB_RUN_CTRL_ECALL_EN
      ecall_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HOLD: begin
          core_rst_n_d = 1'b0;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d      = ST_RUN;
            hold_cnt_d   = {HOLD_W{1'b0}};
            core_rst_n_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          cycle_cnt_d = sat_inc(cycle_cnt_q);
          if (i_insn_vld) begin
            insn_cnt_d = sat_inc(insn_cnt_q);
            rep_cnt_d  = rep_next_s;
            last_pc_d  = i_pc;
          end else begin
            insn_cnt_d = insn_cnt_q;
          end
          // Halt outranks a coincident timeout.
          if (halt_any_s) begin
            state_d      = ST_DONE;
            done_pulse_d = 1'b1;
            halted_d     = 1'b1;
`ifdef TB_RUN_CTRL_ECALL_EN
            ecall_d      = ecall_hit_s;
`endif
          end else if (timeout_hit_s) begin
            state_d      = ST_DONE;
            done_pulse_d = 1'b1;
            timeout_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d      = ST_HOLD;
          hold_cnt_d   = {HOLD_W{1'b0}};
          core_rst_n_d = 1'b0;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= {HOLD_W{1'b0}};
      cycle_cnt_q  <= {CNT_W{1'b0}};
      insn_cnt_q   <= {CNT_W{1'b0}};
      rep_cnt_q    <= {REP_W{1'b0}};
      last_pc_q    <= 32'h00000000;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef TB_RUN_CTRL_ECALL_EN
      ecall_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      insn_cnt_q   <= insn_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      last_pc_q    <= last_pc_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
`ifdef TB_RUN_CTRL_ECALL_EN
      ecall_q      <= ecall_d;
`endif
    end
  end

  assign o_core_rst_n = core_rst_n_q;
  assign o_running    = running_q;
  assign o_done       = done_q;
  assign o_done_pulse = done_pulse_q;
  assign o_halted     = halted_q;
  assign o_timeout    = timeout_q;
  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_insn_cnt   = insn_cnt_q;
`ifdef TB_RUN_CTRL_ECALL_EN
  assign o_ecall      = ecall_q;
`endif

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Bench for tb_run_ctrl: directed scenarios plus random stimulus, checked every cycle against
// a run-level reference model (phase, elapsed hold cycles, counters, halt streak).
module tb_tb_run_ctrl;

  localparam int RST_CYCLES  = 2;
  localparam int MAX_CYCLES  = 20;
  localparam int HALT_REPEAT = 2;
  localparam logic [31:0] HALT  = 32'h0000006f;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] insn = 32'h0;
  logic        vld = 1'b0;
  logic        core_rst_n, running, done, done_pulse, halted, timeout;
  logic [31:0] cycle_cnt, insn_cnt;
`ifdef TB_RUN_CTRL_ECALL_EN
  logic        ecall;
`endif

  int checks = 0;
  int failures = 0;

  // reference model: phase 0=hold 1=run 2=done
  int          m_phase, m_hold, m_cyc, m_ins, m_streak;
  logic [31:0] m_last_pc;
  bit          m_halted, m_timeout, m_pulse;
`ifdef TB_RUN_CTRL_ECALL_EN
  bit          m_ecall;
`endif

  tb_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .HALT_INSN  (HALT),
    .HALT_REPEAT(HALT_REPEAT),
    .CNT_W      (32)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_restart   (restart),
    .i_pc        (pc),
    .i_insn      (insn),
    .i_insn_vld  (vld),
    .o_core_rst_n(core_rst_n),
    .o_running   (running),
    .o_done      (done),
    .o_done_pulse(done_pulse),
    .o_halted    (halted),
    .o_timeout   (timeout),
`ifdef TB_RUN_CTRL_ECALL_EN
    .o_ecall     (ecall),
`endif
    .o_cycle_cnt (cycle_cnt),
    .o_insn_cnt  (insn_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_hold = 0; m_cyc = 0; m_ins = 0; m_streak = 0;
    m_last_pc = 32'h0; m_halted = 1'b0; m_timeout = 1'b0; m_pulse = 1'b0;
`ifdef TB_RUN_CTRL_ECALL_EN
    m_ecall = 1'b0;
`endif
  endtask

  task automatic model_step(input bit r, input logic [31:0] p, input logic [31:0] i, input bit v);
    bit hit;
    bit last;
`ifdef TB_RUN_CTRL_ECALL_EN
    bit hit_ecall;
    hit_ecall = 1'b0;
`endif
    m_pulse = 1'b0;
    if (r) begin
      model_clear();
    end else if (m_phase == 0) begin
      m_hold++;
      if (m_hold == RST_CYCLES) begin
        m_phase = 1;
        m_hold  = 0;
      end
    end else if (m_phase == 1) begin
      hit  = 1'b0;
      last = (m_cyc + 1 == MAX_CYCLES);
      m_cyc++;
      if (v) begin
        m_ins++;
        if (i == HALT) m_streak = (p == m_last_pc) ? m_streak + 1 : 1;
        else m_streak = 0;
        m_last_pc = p;
        hit = (m_streak >= HALT_REPEAT);
`ifdef TB_RUN_CTRL_ECALL_EN
        if (i == ECALL) begin
          hit = 1'b1;
          hit_ecall = 1'b1;
        end
`endif
      end
      if (hit) begin
        m_phase = 2; m_pulse = 1'b1; m_halted = 1'b1;
`ifdef TB_RUN_CTRL_ECALL_EN
        m_ecall = hit_ecall;
`endif
      end else if (last) begin
        m_phase = 2; m_pulse = 1'b1; m_timeout = 1'b1;
      end
    end
  endtask

  task automatic chk_all();
    chk("core_rst_n", 32'(core_rst_n), 32'(m_phase != 0));
    chk("running",    32'(running),    32'(m_phase == 1));
    chk("done",       32'(done),       32'(m_phase == 2));
    chk("done_pulse", 32'(done_pulse), 32'(m_pulse));
    chk("halted",     32'(halted),     32'(m_halted));
    chk("timeout",    32'(timeout),    32'(m_timeout));
    chk("cycle_cnt",  cycle_cnt,       32'(m_cyc));
    chk("insn_cnt",   insn_cnt,        32'(m_ins));
`ifdef TB_RUN_CTRL_ECALL_EN
    chk("ecall",      32'(ecall),      32'(m_ecall));
`endif
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    x = $urandom;
    if (x == HALT || x == ECALL) x = 32'h00000013;
    return x;
  endfunction

  task automatic step(input bit r, input logic [31:0] p, input logic [31:0] i, input bit v);
    restart = r; pc = p; insn = i; vld = v;
    @(posedge clk);
    model_step(r, p, i, v);
    #1;
    chk_all();
  endtask

  task automatic idle();
    step(1'b0, $urandom, rand_insn(), 1'b0);
  endtask

  task automatic restart_run();
    step(1'b1, $urandom, rand_insn(), 1'b1);
    idle();
    idle();
  endtask

  initial begin
    model_clear();
    #1;
    chk_all();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;

    // reset release: core reset held for RST_CYCLES clocks
    idle();
    chk("rst_hold_1", 32'(core_rst_n), 32'd0);
    idle();
    chk("rst_release", 32'(core_rst_n), 32'd1);
    chk("rst_running", 32'(running), 32'd1);

    // 5 ordinary instructions then jump-to-self twice at 0x40
    for (int k = 0; k < 5; k++) step(1'b0, 32'h100 + 32'(4 * k), rand_insn(), 1'b1);
    step(1'b0, 32'h40, HALT, 1'b1);
    chk("halt_first_not_done", 32'(done), 32'd0);
    step(1'b0, 32'h40, HALT, 1'b1);
    chk("halt_pulse", 32'(done_pulse), 32'd1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_insn_cnt", insn_cnt, 32'd7);
    chk("halt_cycle_cnt", cycle_cnt, 32'd7);
    for (int k = 0; k < 3; k++) step(1'b0, $urandom, rand_insn(), 1'b1);
    chk("frozen_insn_cnt", insn_cnt, 32'd7);
    chk("pulse_once", 32'(done_pulse), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);

    // restart from DONE
    step(1'b1, 32'h0, 32'h0, 1'b0);
    chk("restart_rst_low", 32'(core_rst_n), 32'd0);
    chk("restart_halted_clr", 32'(halted), 32'd0);
    idle();
    idle();
    chk("restart_run", 32'(running), 32'd1);
    chk("restart_cnt0", cycle_cnt, 32'd0);

    // PC change resets the streak; an invalid cycle does not
    step(1'b0, 32'h40, HALT, 1'b1);
    step(1'b0, 32'h44, HALT, 1'b1);
    chk("pcchg_not_done", 32'(done), 32'd0);
    step(1'b0, 32'h44, HALT, 1'b0);
    chk("gap_not_done", 32'(done), 32'd0);
    step(1'b0, 32'h44, HALT, 1'b1);
    chk("gap_halt", 32'(halted), 32'd1);
    chk("gap_insn_cnt", insn_cnt, 32'd3);

    // random run to timeout, with one ecall in it
    restart_run();
    for (int j = 0; j < 25; j++) begin
      if (j == 3) step(1'b0, $urandom, ECALL, 1'b1);
      else step(1'b0, $urandom, rand_insn(), 1'($urandom_range(0, 1)));
    end
`ifdef TB_RUN_CTRL_ECALL_EN
    chk("ecall_halted", 32'(halted), 32'd1);
    chk("ecall_flag", 32'(ecall), 32'd1);
    chk("ecall_cycle_cnt", cycle_cnt, 32'd4);
`else
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_not_halted", 32'(halted), 32'd0);
    chk("to_cycle_cnt", cycle_cnt, 32'(MAX_CYCLES));
`endif

    // halt completes on the last budget cycle: halt wins
    restart_run();
    for (int j = 0; j < MAX_CYCLES - 2; j++) step(1'b0, $urandom, rand_insn(), 1'b1);
    step(1'b0, 32'h80, HALT, 1'b1);
    step(1'b0, 32'h80, HALT, 1'b1);
    chk("tie_halted", 32'(halted), 32'd1);
    chk("tie_timeout", 32'(timeout), 32'd0);
    chk("tie_cycle_cnt", cycle_cnt, 32'(MAX_CYCLES));

    // restart coincident with halt, then restart again in HOLD
    restart_run();
    step(1'b0, 32'h40, HALT, 1'b1);
    step(1'b1, 32'h40, HALT, 1'b1);
    chk("rs_win_pulse", 32'(done_pulse), 32'd0);
    chk("rs_win_done", 32'(done), 32'd0);
    idle();
    step(1'b1, 32'h0, 32'h0, 1'b0);
    idle();
    chk("hold_ext_low", 32'(core_rst_n), 32'd0);
    idle();
    chk("hold_ext_high", 32'(core_rst_n), 32'd1);

    // asynchronous reset mid-run
    for (int j = 0; j < 5; j++) step(1'b0, $urandom, rand_insn(), 1'b1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_all();
    chk("arst_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
    idle();
    idle();
    for (int j = 0; j < 3; j++) step(1'b0, 32'h200 + 32'(4 * j), rand_insn(), 1'b1);
    chk("arst_rerun_cnt", insn_cnt, 32'd3);

    // random stress with restarts and halt attempts
    for (int j = 0; j < 300; j++) begin
      logic [31:0] ri;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 8) ri = HALT;
      else if (sel == 8) ri = ECALL;
      else ri = rand_insn();
      step(1'($urandom_range(0, 39) == 0), 32'h40 + 32'(4 * $urandom_range(0, 2)), ri,
           1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_run_ctrl.md
Name: tb_run_ctrl

Overview:
- Parametrised run controller for core-level simulation and FPGA bring-up; replaces fixed-delay reset, fixed `#` timeout and manual halt watching.
- Sequences the core reset, counts cycles and retired instructions, and detects program halt (jump-to-self) or timeout.
- Reports sticky status and supports restart without a global reset.
- Sits between the clock/reset source and the core (singlecycle or successors); observes the core's PC/instruction/valid debug outputs.

Parameters:
- RST_CYCLES, 2, cycles o_core_rst_n is held low after reset or restart (>=1)
- MAX_CYCLES, 1000, RUN-state cycle budget before timeout (>=1)
- HALT_INSN, 32'h0000006f, instruction word treated as halt (jal x0,0)
- HALT_REPEAT, 2, consecutive valid halt instructions at the same PC needed to declare halt (>=1)
- CNT_W, 32, width of the cycle and instruction counters

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_restart  in  1  single-cycle restart request
- i_pc  in  32  core PC debug (o_pc_debug)
- i_insn  in  32  current instruction word
- i_insn_vld  in  1  instruction retired this cycle
- o_core_rst_n  out  1  registered active-low reset to the core
- o_running  out  1  high in RUN
- o_done  out  1  sticky; high in DONE
- o_done_pulse  out  1  one cycle on entry to DONE
- o_halted  out  1  DONE reached by halt detection
- o_timeout  out  1  DONE reached by cycle budget
- o_cycle_cnt  out  CNT_W  RUN cycles elapsed
- o_insn_cnt  out  CNT_W  valid instructions retired in RUN

Behaviour:
- Reset: i_rst_n low asynchronously forces state HOLD. All outputs are 0, including o_core_rst_n (core held in reset). All internal counters and last-PC are cleared.
- HOLD: the hold counter increments each cycle. After RST_CYCLES cycles in HOLD:
  - o_core_rst_n goes 1 on the same edge as entry to RUN.
  - Total latency from reset deassertion to o_core_rst_n=1 is exactly RST_CYCLES clocks.
- RUN: o_running=1.
  - o_cycle_cnt increments every cycle.
  - o_insn_cnt increments on each cycle with i_insn_vld=1.
  - Both counters saturate at all-ones.
- Halt detection (RUN only), evaluated on cycles with i_insn_vld=1:
  - If i_insn==HALT_INSN and i_pc==last_pc, the repeat count increments.
  - If i_insn==HALT_INSN and i_pc differs, the repeat count is set to 1.
  - Otherwise the repeat count is cleared.
  - last_pc is updated on every valid cycle.
  - Cycles with i_insn_vld=0 leave the repeat count and last_pc unchanged.
  - Halt is declared on the cycle the repeat count reaches HALT_REPEAT. With HALT_REPEAT=1, the first valid halt instruction is sufficient.
- Timeout: declared when o_cycle_cnt==MAX_CYCLES-1 in RUN, so exactly MAX_CYCLES RUN cycles elapse.
- Simultaneous halt and timeout on the same cycle: halt wins; o_halted=1, o_timeout=0.
- Entering DONE on a halt or timeout cycle:
  - The transition happens on the next edge.
  - o_done and o_done_pulse assert for that first DONE cycle; o_done_pulse lasts exactly one cycle.
  - o_halted or o_timeout is set (mutually exclusive).
  - The counters include the terminating cycle, then freeze.
- DONE:
  - o_done, o_halted and o_timeout are sticky and o_running=0.
  - o_core_rst_n stays 1; the core is not re-reset and keeps free-running.
  - Inputs are ignored except i_restart.
- i_restart in RUN or DONE:
  - Next state is HOLD; o_core_rst_n drops to 0 on the next edge.
  - Counters, repeat count, status flags and last_pc are all cleared.
  - The HOLD sequence then repeats.
- i_restart in HOLD: the hold counter restarts from 0 and the reset period is extended.
- i_restart coincident with a halt/timeout condition: restart wins; no o_done_pulse.
- Reset mid-operation: asynchronous return to HOLD with all outputs 0, identical to power-up.

Optional Feature:
- Macro: TB_RUN_CTRL_ECALL_EN.
- Defined: a valid 32'h00000073 (ecall) in RUN is an immediate halt regardless of HALT_REPEAT or PC.
  - It sets o_halted and exposes o_ecall (1-bit, sticky, cleared like other flags) to distinguish it from jump-to-self.
  - It takes priority over timeout in the same cycle.
- Undefined: ecall is an ordinary instruction; the o_ecall port does not exist.

Test Plan:
- Reset with RST_CYCLES=2 -> o_core_rst_n=0 for 2 clocks after i_rst_n rises, then 1; o_running=1 same edge; all other outputs 0 before that.
- 5 valid non-halt instructions then HALT_INSN twice at PC 0x40 (HALT_REPEAT=2) -> one-cycle o_done_pulse, o_halted=1, o_insn_cnt=7, counters frozen afterwards.
- HALT_INSN at PC 0x40 then 0x44, then a valid gap cycle with i_insn_vld=0, then 0x44 again -> halt declared only on the second 0x44 (invalid cycle does not break the sequence).
- MAX_CYCLES=20, no halt -> o_timeout=1 with o_cycle_cnt=20; halt and timeout on the same cycle -> o_halted=1, o_timeout=0.
- i_restart in DONE, and separately i_rst_n low mid-RUN -> flags and counters 0, o_core_rst_n low for RST_CYCLES, then a new run counts from 0.
- With TB_RUN_CTRL_ECALL_EN: a single valid 0x00000073 -> o_halted=1, o_ecall=1 one edge later; without the macro -> the run continues to timeout.
